// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: PS/2 scancode prefix decoder, Shift/Caps Lock tracker and key-event FIFO.
// Build option: define KBD_TYPEMATIC_FILTER_EN to suppress typematic repeats of the last make.
module kbd_event_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         fclk,
  input  logic                         rst,
  input  logic [7:0]                   code_in,
  input  logic                         code_valid,
  input  logic                         rd_en,
  input  logic                         ovf_clr,
  output logic                         ev_valid,
  output logic [9:0]                   ev_data,
  output logic [$clog2(FIFO_DEPTH):0]  ev_count,
  output logic                         overflow,
  output logic                         shift_held,
  output logic                         caps_lock
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            emit_q, emit_d;
  logic [9:0]      ev_q, ev_d;
  logic            code_err;

  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ev_valid_q;
  logic [9:0]      ev_data_q, head_d;
  logic            ovf_q, ovf_d;
  logic            lsh_q, lsh_d;
  logic            rsh_q, rsh_d;
  logic            caps_q, caps_d;

  logic            suppress;
  logic            push;
  logic            pop;
  logic            full;
  logic            wr_ok;
  logic            drop;

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic            hist_vld_q, hist_vld_d;
  logic [8:0]      hist_q, hist_d;
`endif

  assign code_err = (code_in == 8'h00) || (code_in == 8'hFF);

  // Prefix decoder: strips E0/F0 and registers the completed event.
  always_comb begin
    state_d = state_q;
    emit_d  = 1'b0;
    ev_d    = ev_q;
    if (code_valid) begin
      case (state_q)
        IDLE: begin
          if (code_in == CODE_E0) begin
            state_d = GOT_E0;
          end else if (code_in == CODE_F0) begin
            state_d = GOT_F0;
          end else if (!code_err) begin
            emit_d = 1'b1;
            ev_d   = {2'b00, code_in};
          end
        end
        GOT_E0: begin
          if (code_in == CODE_F0) begin
            state_d = GOT_E0F0;
          end else if (code_in != CODE_E0) begin
            state_d = IDLE;
            if (!code_err) begin
              emit_d = 1'b1;
              ev_d   = {2'b01, code_in};
            end
          end
        end
        GOT_F0: begin
          if (code_in == CODE_E0) begin
            state_d = GOT_E0F0;
          end else if (code_in != CODE_F0) begin
            state_d = IDLE;
            if (!code_err) begin
              emit_d = 1'b1;
              ev_d   = {2'b10, code_in};
            end
          end
        end
        GOT_E0F0: begin
          if ((code_in != CODE_E0) && (code_in != CODE_F0)) begin
            state_d = IDLE;
            if (!code_err) begin
              emit_d = 1'b1;
              ev_d   = {2'b11, code_in};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  assign suppress = emit_q && !ev_q[9] && hist_vld_q && (hist_q == ev_q[8:0]);
`else
  assign suppress = 1'b0;
`endif

  assign push  = emit_q && !suppress;
  assign pop   = rd_en && (count_q != '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO bookkeeping, show-ahead head and modifier tracking.
  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    head_d = (wr_ok && (rd_ptr_d == wr_ptr_q)) ? ev_q : mem_q[rd_ptr_d];
    ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    lsh_d  = lsh_q;
    rsh_d  = rsh_q;
    caps_d = caps_q;
    if (emit_q && !ev_q[8]) begin
      if (ev_q[7:0] == CODE_LSHIFT) lsh_d = !ev_q[9];
      if (ev_q[7:0] == CODE_RSHIFT) rsh_d = !ev_q[9];
      if ((ev_q[7:0] == CODE_CAPS) && !ev_q[9] && !suppress) caps_d = !caps_q;
    end

`ifdef KBD_TYPEMATIC_FILTER_EN
    hist_vld_d = hist_vld_q;
    hist_d     = hist_q;
    if (emit_q) begin
      if (ev_q[9]) begin
        hist_vld_d = 1'b0;
      end else if (!suppress) begin
        hist_vld_d = 1'b1;
        hist_d     = ev_q[8:0];
      end
    end
`endif
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      emit_q     <= 1'b0;
      ev_q       <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
      ovf_q      <= 1'b0;
      lsh_q      <= 1'b0;
      rsh_q      <= 1'b0;
      caps_q     <= 1'b0;
`ifdef KBD_TYPEMATIC_FILTER_EN
      hist_vld_q <= 1'b0;
      hist_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      emit_q     <= emit_d;
      ev_q       <= ev_d;
      if (wr_ok) mem_q[wr_ptr_q] <= ev_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ev_valid_q <= (count_d != '0);
      ev_data_q  <= head_d;
      ovf_q      <= ovf_d;
      lsh_q      <= lsh_d;
      rsh_q      <= rsh_d;
      caps_q     <= caps_d;
`ifdef KBD_TYPEMATIC_FILTER_EN
      hist_vld_q <= hist_vld_d;
      hist_q     <= hist_d;
`endif
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_data    = ev_data_q;
  assign ev_count   = count_q;
  assign overflow   = ovf_q;
  assign shift_held = lsh_q | rsh_q;
  assign caps_lock  = caps_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb_kbd_event_ctrl: directed and randomized scancode streams checked against a queue-based model.
module tb_kbd_event_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef KBD_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          fclk;
  logic          rst;
  logic [7:0]    code_in;
  logic          code_valid;
  logic          rd_en;
  logic          ovf_clr;
  logic          ev_valid;
  logic [9:0]    ev_data;
  logic [CW-1:0] ev_count;
  logic          overflow;
  logic          shift_held;
  logic          caps_lock;

  kbd_event_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .fclk       (fclk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .rd_en      (rd_en),
    .ovf_clr    (ovf_clr),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .ev_count   (ev_count),
    .overflow   (overflow),
    .shift_held (shift_held),
    .caps_lock  (caps_lock)
  );

  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: prefix flags, pending decoded event, event queue, modifier bits.
  logic [9:0] mq[$];
  bit         pend_v;
  logic [9:0] pend_ev;
  bit         f_ext, f_brk;
  bit         m_lsh, m_rsh, m_caps, m_ovf;
  bit         h_v;
  logic [8:0] h_ev;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    mq.delete();
    pend_v = 0; pend_ev = '0;
    f_ext = 0; f_brk = 0;
    m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0;
    h_v = 0; h_ev = '0;
  endfunction

  function automatic void model_edge(bit cv, logic [7:0] c, bit rd, bit clr);
    bit dropped = 0;
    bit supp;
    if (rd && mq.size() != 0) void'(mq.pop_front());
    if (pend_v) begin
      supp = FILT && !pend_ev[9] && h_v && (h_ev == pend_ev[8:0]);
      if (!pend_ev[8]) begin
        if (pend_ev[7:0] == 8'h12) m_lsh = !pend_ev[9];
        if (pend_ev[7:0] == 8'h59) m_rsh = !pend_ev[9];
        if (pend_ev[7:0] == 8'h58 && !pend_ev[9] && !supp) m_caps = !m_caps;
      end
      if (pend_ev[9]) h_v = 0;
      else if (!supp) begin h_v = 1; h_ev = pend_ev[8:0]; end
      if (!supp) begin
        if (mq.size() < DEPTH) mq.push_back(pend_ev);
        else dropped = 1;
      end
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    pend_v = 0;
    if (cv) begin
      if (c == 8'hE0) f_ext = 1;
      else if (c == 8'hF0) f_brk = 1;
      else begin
        if (c != 8'h00 && c != 8'hFF) begin
          pend_v  = 1;
          pend_ev = {f_brk, f_ext, c};
        end
        f_ext = 0;
        f_brk = 0;
      end
    end
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge fclk) begin
    if (rst && chk_en) begin
      check("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
      check("ev_count", 32'(ev_count), 32'(mq.size()));
      if (mq.size() != 0) check("ev_data", 32'(ev_data), 32'(mq[0]));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("shift_held", 32'(shift_held), 32'(m_lsh | m_rsh));
      check("caps_lock", 32'(caps_lock), 32'(m_caps));
    end
  end

  task automatic step(input bit cv, input logic [7:0] c, input bit rd, input bit clr);
    code_valid = cv; code_in = c; rd_en = rd; ovf_clr = clr;
    @(posedge fclk); #1;
    model_edge(cv, c, rd, clr);
    code_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    model_clear();
    @(negedge fclk);
    check("rst_ev_valid", 32'(ev_valid), 32'd0);
    check("rst_ev_data", 32'(ev_data), 32'd0);
    check("rst_ev_count", 32'(ev_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_shift", 32'(shift_held), 32'd0);
    check("rst_caps", 32'(caps_lock), 32'd0);
    @(posedge fclk); #1;
    rst = 1'b1;
  endtask

  logic [7:0] tbl [10];

  initial begin
    rst = 1'b0; code_in = '0; code_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    model_clear();
    @(posedge fclk); #1;
    reset_pulse();
    chk_en = 1'b1;

    // Make then break, FIFO order.
    send(8'h1C); send(8'hF0); send(8'h1C); idle(1);
    check("s1_count", 32'(ev_count), 32'd2);
    check("s1_head0", 32'(ev_data), 32'h01C);
    drain(1);
    check("s1_head1", 32'(ev_data), 32'h21C);
    drain(1);
    check("s1_empty", 32'(ev_valid), 32'd0);

    // Extended make and break.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(1);
    check("s2_head0", 32'(ev_data), 32'h175);
    drain(1);
    check("s2_head1", 32'(ev_data), 32'h375);
    drain(1);
    send(8'h1C); idle(1);
    check("s2_idle_after", 32'(ev_data), 32'h01C);
    drain(1);

    // Modifiers.
    send(8'h12); idle(1);
    check("s3_shift_make", 32'(shift_held), 32'd1);
    send(8'hE0); send(8'h12); idle(1);
    check("s3_shift_ext", 32'(shift_held), 32'd1);
    send(8'hF0); send(8'h12); idle(1);
    check("s3_shift_brk", 32'(shift_held), 32'd0);
    drain(3);
    send(8'h58); idle(1);
    check("s3_caps_on", 32'(caps_lock), 32'd1);
    send(8'hF0); send(8'h58); send(8'h58); idle(1);
    check("s3_caps_off", 32'(caps_lock), 32'd0);
    drain(3);

    // Overflow, full push+pop, overflow clear.
    reset_pulse();
    send(8'h1C); send(8'h1D); send(8'h1E); send(8'h21); send(8'h22); idle(1);
    check("s4_count_full", 32'(ev_count), 32'd4);
    check("s4_ovf_set", 32'(overflow), 32'd1);
    check("s4_head", 32'(ev_data), 32'h01C);
    send(8'h23); step(1'b0, 8'h00, 1'b1, 1'b0);
    check("s4_count_pushpop", 32'(ev_count), 32'd4);
    check("s4_head_pushpop", 32'(ev_data), 32'h01D);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("s4_ovf_clr", 32'(overflow), 32'd0);
    drain(3);
    check("s4_last", 32'(ev_data), 32'h023);
    drain(1);

    // Typematic repeats.
    reset_pulse();
    send(8'h1C); send(8'h1C); send(8'h1C); idle(1);
    check("s5_repeat_count", 32'(ev_count), FILT ? 32'd1 : 32'd3);
    drain(3);
    send(8'hF0); send(8'h1C); send(8'h1C); idle(1);
    check("s5_rearm_count", 32'(ev_count), 32'd2);
    drain(1);
    check("s5_rearm_make", 32'(ev_data), 32'h01C);
    drain(1);

    // Reset mid-prefix and keyboard error byte.
    send(8'hE0);
    reset_pulse();
    send(8'h1C); idle(1);
    check("s6_no_ext", 32'(ev_data), 32'h01C);
    reset_pulse();
    send(8'hFF); send(8'h1C); idle(1);
    check("s6_err_count", 32'(ev_count), 32'd1);
    check("s6_err_head", 32'(ev_data), 32'h01C);
    drain(1);

    // Randomized streams against the model.
    tbl = '{8'h1C, 8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0, 8'h00, 8'hFF, 8'h75, 8'h1C};
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] c;
      int unsigned idx;
      bit rd;
      idx = $urandom_range(0, 10);
      c = (idx == 10) ? 8'($urandom) : tbl[idx];
      rd = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) reset_pulse();
      else step($urandom_range(0, 3) != 0, c, rd, $urandom_range(0, 15) == 0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
